switch_reader: RTL
==================

Name: switch_reader

Overview:
- Input-side counterpart to the 16-bit LED output port. Samples the 16 board DIP switches, synchronises and debounces them, and tracks which bits changed.
- Exposes a two-word, read-only register interface to the CPU memory/IO stage.
- Read data is registered with one-cycle latency.

Parameters:
- WIDTH, 16, number of switch inputs and width of read data.
- DEBOUNCE_DIV, 50000, clock cycles per debounce sample tick (must be >= 2).
- STABLE_SAMPLES, 4, consecutive identical ticks required to accept a new level (must be >= 2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- sw_port_sw  input  WIDTH  raw asynchronous switch levels.
- rd_en  input  1  one-cycle read strobe from CPU IO stage.
- rd_addr  input  1  0 = data word, 1 = change-mask word.
- rd_data  output  WIDTH  registered read result.
- sw_level  output  WIDTH  current debounced switch value, for direct fabric use.
- changed  output  1  high while any change-mask bit is set.
- sw_irq  output  1  present only with SWITCH_IRQ_EN.

Behaviour:
- Reset (rst==0 at a rising edge) clears:
  - both sync stages, tick counter, all history bits, sw_level, change_mask, rd_data;
  - changed=0 and sw_irq=0.
  - Reset mid-debounce discards all partial history.
- Synchroniser: two flops per bit; sync2 is the stable sampled value. Raw-to-sync2 latency is 2 cycles.
- Tick counter:
  - Counts 0..DEBOUNCE_DIV-1, then wraps to 0.
  - tick=1 in the cycle the count equals DEBOUNCE_DIV-1, giving exactly one tick per DEBOUNCE_DIV cycles.
- Per-bit history: an STABLE_SAMPLES-deep shift register; on tick it shifts in sync2[i].
- Acceptance: in the cycle after a tick, if all history entries of bit i are equal and differ from sw_level[i]:
  - sw_level[i] takes that value;
  - change_mask[i] is set in the same cycle.
- Any input pulse shorter than STABLE_SAMPLES consecutive ticks never reaches sw_level.
- change_mask:
  - Sticky OR of every accepted bit change.
  - Cleared entirely by a read of address 0 (rd_en=1, rd_addr=0).
  - If a read of address 0 and a new change occur in the same cycle, the new change's bits remain set; all other bits clear.
  - Reads of address 1 never clear it.
- changed = |change_mask, driven combinationally from the register.
- Read port:
  - When rd_en=1, rd_data at the next edge = (rd_addr==0) ? sw_level : change_mask, using pre-edge values.
  - When rd_en=0, rd_data holds.
  - No back-pressure; a read is accepted every cycle.
  - Back-to-back reads of address 0 return the current sw_level each time.
- Width: tick counter width = clog2(DEBOUNCE_DIV). No arithmetic on the data path.

Optional Feature:
- Macro: SWITCH_IRQ_EN.
- Defined:
  - Adds output sw_irq and an internal 1-bit irq_pending.
  - irq_pending sets on any cycle where change_mask gains a bit, and clears on a read of address 0; set wins on collision.
  - sw_irq = irq_pending, registered, reset 0.
- Undefined: no sw_irq port and no irq_pending logic; every other behaviour is identical.

Test Plan:
All scenarios use DEBOUNCE_DIV=4 and STABLE_SAMPLES=4.
- Reset: drive sw_port_sw=16'hFFFF, rst=0 for 3 cycles -> rd_data=0, sw_level=0, changed=0, sw_irq=0. After release, sw_level=16'hFFFF within 2+4*4+2 cycles, and change_mask reads 16'hFFFF.
- Glitch rejection: bit 3 pulses high for 8 cycles (2 ticks), then low -> sw_level stays 16'h0000, changed stays 0 for 40 cycles.
- Stable accept and read-clear:
  - Set sw_port_sw=16'h00A5 and hold -> sw_level=16'h00A5 within 20 cycles.
  - Read addr 1 -> 16'h00A5 one cycle later, and changed stays 1.
  - Read addr 0 -> 16'h00A5, then changed=0 next cycle.
- Collision: bit 0 acceptance in the same cycle as a read of addr 0 -> change_mask=16'h0001 afterwards and changed=1; with SWITCH_IRQ_EN, sw_irq stays 1.
- Hold and latency: rd_en=1, rd_addr=0 for one cycle, then rd_en=0 for 10 cycles while the inputs are stable -> rd_data updates exactly 1 cycle after the strobe and holds unchanged for all 10 cycles.
- Reset mid-debounce: bit 7 held high for 2 ticks, then pulse rst=0 for 1 cycle -> history cleared; sw_level[7] rises only after 4 full ticks post-reset.

Source files
------------

// File: rtl/switch_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : switch_reader                                                |
// | Description : Synchronised, debounced DIP-switch port with a read-only     |
// |               data / change-mask register pair. Define SWITCH_IRQ_EN to    |
// |               add the sw_irq change interrupt output.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module switch_reader #(
    parameter int WIDTH          = 16,
    parameter int DEBOUNCE_DIV   = 50000,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_port_sw,
    input  logic             rd_en,
    input  logic             rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] sw_level,
`ifdef SWITCH_IRQ_EN
    output logic             changed,
    output logic             sw_irq
`else
    output logic             changed
`endif
);

    localparam int                 c_CNT_W    = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_DIV - 1);

    logic [WIDTH-1:0]   r_sync1;
    logic [WIDTH-1:0]   r_sync2;
    logic [c_CNT_W-1:0] r_tick_cnt;
    logic               w_tick;
    logic               r_tick_d;
    logic [WIDTH-1:0]   w_accept;
    logic [WIDTH-1:0]   r_sw_level;
    logic [WIDTH-1:0]   r_change_mask;
    logic [WIDTH-1:0]   w_mask_kept;
    logic [WIDTH-1:0]   r_rd_data;
    logic               w_rd0;

    assign w_tick = (r_tick_cnt == c_CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_tick_cnt <= '0;
            r_tick_d   <= 1'b0;
        end else begin
            r_sync1    <= sw_port_sw;
            r_sync2    <= r_sync1;
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + c_CNT_W'(1);
            r_tick_d   <= w_tick;
        end
    end

    // History is evaluated the cycle after the shift so the newest sample counts.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic [STABLE_SAMPLES-1:0] r_hist;

        always_ff @(posedge clk) begin
            if (!rst) begin
                r_hist <= '0;
            end else if (w_tick) begin
                r_hist <= {r_hist[STABLE_SAMPLES-2:0], r_sync2[gi]};
            end
        end

        assign w_accept[gi] = r_tick_d &
                              (((&r_hist) & ~r_sw_level[gi]) |
                               ((~|r_hist) &  r_sw_level[gi]));
    end

    assign w_rd0       = rd_en & ~rd_addr;
    assign w_mask_kept = w_rd0 ? '0 : r_change_mask;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sw_level    <= '0;
            r_change_mask <= '0;
            r_rd_data     <= '0;
        end else begin
            r_sw_level    <= r_sw_level ^ w_accept;
            r_change_mask <= w_mask_kept | w_accept;
            if (rd_en) begin
                r_rd_data <= rd_addr ? r_change_mask : r_sw_level;
            end
        end
    end

    assign sw_level = r_sw_level;
    assign rd_data  = r_rd_data;
    assign changed  = |r_change_mask;

`ifdef SWITCH_IRQ_EN
    logic r_irq_pending;
    logic w_irq_gain;

    // A bit re-accepted during a clearing read still counts as a fresh gain.
    assign w_irq_gain = |(w_accept & ~w_mask_kept);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_irq_pending <= 1'b0;
        end else begin
            r_irq_pending <= w_irq_gain | (r_irq_pending & ~w_rd0);
        end
    end

    assign sw_irq = r_irq_pending;
`endif

endmodule
`default_nettype wire
